// File: rtl/enemy_pkg.sv
// Shared constants for the enemy sequencer: default geometry widths,
// FSM state encoding and single-bit ON/OFF levels.
package enemy_pkg;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 6;

  // FSM state encoding (3-bit, kept as plain constants for legacy tooling)
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GEN       = 3'd1;
  localparam logic [2:0] S_GEN_DONE  = 3'd2;
  localparam logic [2:0] S_DRAW_ARM  = 3'd3;
  localparam logic [2:0] S_DRAW_WAIT = 3'd4;
  localparam logic [2:0] S_DRAW_GAP  = 3'd5;
  localparam logic [2:0] S_DRAW_FIN  = 3'd6;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Index width for n enemies; a single enemy still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enemy_next_alive.sv
// Combinational priority search: lowest set bit of mask at or above start.
// start is one bit wider than an index so "one past the last enemy" is
// representable and simply yields valid = 0.
module enemy_next_alive
  import enemy_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]   mask,
  input  logic [IDX_W:0] start,
  output logic [IDX_W-1:0] idx,
  output logic           valid
);

  logic [N-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = mask[gi] && ((IDX_W+1)'(gi) >= start);
    end
  endgenerate

  // Scan downwards so the lowest candidate is the one that sticks.
  always_comb begin
    idx   = '0;
    valid = OFF;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx   = IDX_W'(i);
        valid = ON;
      end
    end
  end

endmodule

// File: rtl/enemy_sequencer.sv
// Sequences move generation and drawing across NUM_ENEMIES enemies, one at a
// time, skipping dead ones, and muxes the active enemy's pixel stream onto a
// single VGA write port.
module enemy_sequencer #(
  parameter int NUM_ENEMIES = 4,
  parameter int X_W         = enemy_pkg::X_W,
  parameter int Y_W         = enemy_pkg::Y_W,
  parameter int COLOUR_W    = enemy_pkg::COLOUR_W,
  parameter int IDX_W       = enemy_pkg::idx_width(NUM_ENEMIES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            init,
  input  logic                            gen_move,
  input  logic                            draw,
  input  logic [NUM_ENEMIES-1:0]          hit,
  input  logic [NUM_ENEMIES*X_W-1:0]      x_draw_in,
  input  logic [NUM_ENEMIES*Y_W-1:0]      y_draw_in,
  input  logic [NUM_ENEMIES*COLOUR_W-1:0] colour_in,
  input  logic [NUM_ENEMIES-1:0]          vga_write_in,
  input  logic [NUM_ENEMIES-1:0]          draw_done_in,
  output logic [NUM_ENEMIES-1:0]          gen_move_en,
  output logic [NUM_ENEMIES-1:0]          draw_en,
  output logic [X_W-1:0]                  x_draw,
  output logic [Y_W-1:0]                  y_draw,
  output logic [COLOUR_W-1:0]             colour,
  output logic                            VGA_write,
  output logic                            gen_move_done,
  output logic                            draw_done,
  output logic [NUM_ENEMIES-1:0]          alive,
  output logic [IDX_W:0]                  alive_count,
  output logic                            all_dead
);

  import enemy_pkg::*;

  logic [2:0]             state_reg;
  logic [IDX_W-1:0]       cur_reg;
  logic                   cur_valid_reg;
  logic [NUM_ENEMIES-1:0] draw_en_reg;
  logic [NUM_ENEMIES-1:0] alive_reg;

  // Kills landing this cycle are already excluded when picking the next
  // enemy, so an enemy hit just ahead of the cursor is never selected.
  logic [NUM_ENEMIES-1:0] live_mask;
  logic [IDX_W:0]         next_start;
  logic [IDX_W-1:0]       first_idx;
  logic                   first_valid;
  logic [IDX_W-1:0]       next_idx;
  logic                   next_valid;
  logic [NUM_ENEMIES-1:0] onehot_cur;

  assign live_mask  = alive_reg & ~hit;
  assign next_start = {1'b0, cur_reg} + {{IDX_W{1'b0}}, 1'b1};

  enemy_next_alive #(.N(NUM_ENEMIES), .IDX_W(IDX_W)) u_first_alive (
    .mask  (live_mask),
    .start ('0),
    .idx   (first_idx),
    .valid (first_valid)
  );

  enemy_next_alive #(.N(NUM_ENEMIES), .IDX_W(IDX_W)) u_next_alive (
    .mask  (live_mask),
    .start (next_start),
    .idx   (next_idx),
    .valid (next_valid)
  );

  // Per-enemy slices of the packed pixel buses, plus the cursor as one-hot
  logic [X_W-1:0]      x_slice [NUM_ENEMIES];
  logic [Y_W-1:0]      y_slice [NUM_ENEMIES];
  logic [COLOUR_W-1:0] c_slice [NUM_ENEMIES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENEMIES; gi++) begin : g_slice
      assign x_slice[gi]    = x_draw_in[gi*X_W +: X_W];
      assign y_slice[gi]    = y_draw_in[gi*Y_W +: Y_W];
      assign c_slice[gi]    = colour_in[gi*COLOUR_W +: COLOUR_W];
      assign onehot_cur[gi] = (cur_reg == IDX_W'(gi));
    end
  endgenerate

  // Alive mask: sticky kills, revived only by init (same-cycle hits ignored)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alive_reg <= '1;
    end else if (init) begin
      alive_reg <= '1;
    end else begin
      alive_reg <= alive_reg & ~hit;
    end
  end

  // Phase FSM: walks the cursor over alive enemies for each phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cur_reg       <= '0;
      cur_valid_reg <= OFF;
      draw_en_reg   <= '0;
    end else if (init) begin
      state_reg     <= S_IDLE;
      cur_reg       <= '0;
      cur_valid_reg <= OFF;
      draw_en_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (gen_move) begin
            cur_reg   <= first_idx;
            state_reg <= first_valid ? S_GEN : S_GEN_DONE;
          end else if (draw) begin
            cur_reg       <= first_idx;
            cur_valid_reg <= first_valid;
            state_reg     <= S_DRAW_ARM;
          end
        end
        S_GEN: begin
          if (!gen_move) begin
            state_reg <= S_IDLE;
          end else if (next_valid) begin
            cur_reg <= next_idx;
          end else begin
            state_reg <= S_GEN_DONE;
          end
        end
        S_GEN_DONE: begin
          if (!gen_move) state_reg <= S_IDLE;
        end
        S_DRAW_ARM: begin
          if (!draw) begin
            state_reg   <= S_IDLE;
            draw_en_reg <= '0;
          end else if (cur_valid_reg) begin
            draw_en_reg <= onehot_cur;
            state_reg   <= S_DRAW_WAIT;
          end else begin
            state_reg <= S_DRAW_FIN;
          end
        end
        S_DRAW_WAIT: begin
          // A kill on the current enemy does not interrupt its sprite.
          if (!draw) begin
            state_reg   <= S_IDLE;
            draw_en_reg <= '0;
          end else if (draw_done_in[cur_reg]) begin
            draw_en_reg <= '0;
            state_reg   <= S_DRAW_GAP;
          end
        end
        S_DRAW_GAP: begin
          if (!draw) begin
            state_reg <= S_IDLE;
          end else if (next_valid) begin
            cur_reg       <= next_idx;
            cur_valid_reg <= ON;
            state_reg     <= S_DRAW_ARM;
          end else begin
            state_reg <= S_DRAW_FIN;
          end
        end
        S_DRAW_FIN: begin
          if (!draw) state_reg <= S_IDLE;
        end
        default: begin
          state_reg   <= S_IDLE;
          draw_en_reg <= '0;
        end
      endcase
    end
  end

  // Popcount of the alive mask
  always_comb begin
    alive_count = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      alive_count = alive_count + (IDX_W+1)'(alive_reg[i]);
    end
  end

  assign alive         = alive_reg;
  assign all_dead      = (alive_reg == '0);
  assign draw_en       = draw_en_reg;
  assign gen_move_en   = (state_reg == S_GEN && gen_move) ? onehot_cur : '0;
  assign gen_move_done = (state_reg == S_GEN_DONE) && gen_move;
  assign draw_done     = (state_reg == S_DRAW_FIN) && draw;

  // Pixel port follows the selected enemy only while its sprite is drawing
  assign x_draw    = (state_reg == S_DRAW_WAIT) ? x_slice[cur_reg] : '0;
  assign y_draw    = (state_reg == S_DRAW_WAIT) ? y_slice[cur_reg] : '0;
  assign colour    = (state_reg == S_DRAW_WAIT) ? c_slice[cur_reg] : '0;
  assign VGA_write = (state_reg == S_DRAW_WAIT) ? vga_write_in[cur_reg] : OFF;

endmodule

// File: tb/tb_enemy_sequencer.sv
// Self-checking bench for enemy_sequencer (4 enemies): a per-cycle vector
// table for the move-generation phase, kills and init, plus hand-written
// draw frames driven by a stub that finishes each sprite 3 cycles after
// draw_en rises, and an asynchronous reset in the middle of a sprite.
module tb_enemy_sequencer;

  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 6;

  logic clock = 1'b0;
  logic reset;
  logic init, gen_move, draw;
  logic [N-1:0]    hit, vga_write_in, draw_done_in;
  logic [N*XW-1:0] x_draw_in;
  logic [N*YW-1:0] y_draw_in;
  logic [N*CW-1:0] colour_in;
  logic [N-1:0]    gen_move_en, draw_en, alive;
  logic [XW-1:0]   x_draw;
  logic [YW-1:0]   y_draw;
  logic [CW-1:0]   colour;
  logic            VGA_write, gen_move_done, draw_done, all_dead;
  logic [2:0]      alive_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  enemy_sequencer #(.NUM_ENEMIES(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .init          (init),
    .gen_move      (gen_move),
    .draw          (draw),
    .hit           (hit),
    .x_draw_in     (x_draw_in),
    .y_draw_in     (y_draw_in),
    .colour_in     (colour_in),
    .vga_write_in  (vga_write_in),
    .draw_done_in  (draw_done_in),
    .gen_move_en   (gen_move_en),
    .draw_en       (draw_en),
    .x_draw        (x_draw),
    .y_draw        (y_draw),
    .colour        (colour),
    .VGA_write     (VGA_write),
    .gen_move_done (gen_move_done),
    .draw_done     (draw_done),
    .alive         (alive),
    .alive_count   (alive_count),
    .all_dead      (all_dead)
  );

  // Enemy stub: raise done 3 cycles after draw_en rises, drop with draw_en
  int stub_cnt [N];
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) stub_cnt[i] <= draw_en[i] ? stub_cnt[i] + 1 : 0;
  end
  always_comb begin
    draw_done_in = '0;
    for (int i = 0; i < N; i++) draw_done_in[i] = draw_en[i] && (stub_cnt[i] >= 3);
  end

  // Per-enemy pixel data the mux is expected to forward
  function automatic logic [XW-1:0] ex_x(input int i);
    return XW'(100 + i * 37);
  endfunction
  function automatic logic [YW-1:0] ex_y(input int i);
    return YW'(20 + i * 11);
  endfunction
  function automatic logic [CW-1:0] ex_c(input int i);
    return CW'(3 + i * 5);
  endfunction
  function automatic logic ex_vw(input int i);
    return (i != 2);
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       gm, dr, in;
    logic [3:0] hit;
    logic [3:0] e_en;
    logic       e_gdone;
    logic [3:0] e_alive;
    logic [2:0] e_cnt;
    logic       e_dead;
    logic [3:0] e_den;
    logic       e_ddone;
  } vec_t;

  function automatic vec_t mk(input logic gm, input logic dr, input logic in, input logic [3:0] h,
                              input logic [3:0] en, input logic gd, input logic [3:0] al,
                              input logic [2:0] cn, input logic dd, input logic [3:0] den,
                              input logic ddn);
    vec_t v;
    v.gm = gm; v.dr = dr; v.in = in; v.hit = h; v.e_en = en; v.e_gdone = gd;
    v.e_alive = al; v.e_cnt = cn; v.e_dead = dd; v.e_den = den; v.e_ddone = ddn;
    return v;
  endfunction

  // One draw frame; exp_mask lists the enemies expected to be drawn in
  // ascending order, hit_mask is pulsed once when that enemy starts drawing.
  task automatic draw_frame(input string tag, input logic [N-1:0] exp_mask,
                            input logic [N-1:0] hit_mask);
    int order[$];
    int zero_run, high_run, k, j;
    bit done_seen, hit_done;
    logic [N-1:0] prev;
    zero_run = 0; high_run = 0; done_seen = 0; hit_done = 0; prev = '0;
    draw = 1'b1;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(posedge clock); #1;
      hit = '0;
      if (draw_done) begin
        done_seen = 1;
      end else if (draw_en != '0) begin
        k = idx_of(draw_en);
        if (prev == '0) begin
          if (order.size() > 0) chk({tag, " gap"}, zero_run, 2);
          order.push_back(k);
          high_run = 0;
        end
        high_run++;
        zero_run = 0;
        chk({tag, " onehot"}, draw_en, N'(1) << k);
        chk({tag, " pix"}, {VGA_write, x_draw, y_draw, colour},
            {ex_vw(k), ex_x(k), ex_y(k), ex_c(k)});
        if (!hit_done && hit_mask != '0 && draw_en == hit_mask) begin
          hit = hit_mask;
          hit_done = 1;
        end
      end else begin
        if (prev != '0) chk({tag, " wait len"}, high_run, 4);
        zero_run++;
        chk({tag, " idle pix"}, {VGA_write, x_draw, y_draw, colour}, 0);
      end
      prev = draw_en;
    end
    chk({tag, " done"}, done_seen, 1);
    chk({tag, " count"}, order.size(), $countones(exp_mask));
    j = 0;
    for (int i = 0; i < N; i++) begin
      if (exp_mask[i]) begin
        if (j < order.size()) chk({tag, " order"}, order[j], i);
        j++;
      end
    end
    $display("frame %s: drew %0d enemies, alive=%b", tag, order.size(), alive);
    draw = 1'b0;
    #1;
    chk({tag, " done drop"}, draw_done, 0);
    @(posedge clock); #1;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1; init = 0; gen_move = 0; draw = 0; hit = '0;
    vga_write_in = 4'b1011;
    for (int i = 0; i < N; i++) begin
      x_draw_in[i*XW +: XW] = ex_x(i);
      y_draw_in[i*YW +: YW] = ex_y(i);
      colour_in[i*CW +: CW] = ex_c(i);
    end

    //          gm dr in hit      en     gd alive   cnt dd den    ddn
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b1111,4,0,4'b0000,0)); // idle
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0001,0,4'b1111,4,0,4'b0000,0)); // strobes 0..3
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0010,0,4'b1111,4,0,4'b0000,0));
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0100,0,4'b1111,4,0,4'b0000,0));
    vecs.push_back(mk(1,0,0,4'b0000, 4'b1000,0,4'b1111,4,0,4'b0000,0));
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0000,1,4'b1111,4,0,4'b0000,0)); // done
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0000,1,4'b1111,4,0,4'b0000,0)); // held
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b1111,4,0,4'b0000,0)); // release
    vecs.push_back(mk(0,0,0,4'b0101, 4'b0000,0,4'b1010,2,0,4'b0000,0)); // kill 0,2
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0010,0,4'b1010,2,0,4'b0000,0));
    vecs.push_back(mk(1,0,0,4'b0000, 4'b1000,0,4'b1010,2,0,4'b0000,0));
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0000,1,4'b1010,2,0,4'b0000,0));
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b1010,2,0,4'b0000,0));
    vecs.push_back(mk(0,0,1,4'b0000, 4'b0000,0,4'b1111,4,0,4'b0000,0)); // init
    vecs.push_back(mk(1,1,0,4'b0000, 4'b0001,0,4'b1111,4,0,4'b0000,0)); // gen beats draw
    vecs.push_back(mk(1,0,0,4'b0100, 4'b0010,0,4'b1011,3,0,4'b0000,0)); // kill ahead
    vecs.push_back(mk(1,0,0,4'b0000, 4'b1000,0,4'b1011,3,0,4'b0000,0)); // 2 skipped
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0000,1,4'b1011,3,0,4'b0000,0));
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b1011,3,0,4'b0000,0));
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0001,0,4'b1011,3,0,4'b0000,0));
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b1011,3,0,4'b0000,0)); // abort
    vecs.push_back(mk(0,0,1,4'b0000, 4'b0000,0,4'b1111,4,0,4'b0000,0));
    vecs.push_back(mk(0,0,0,4'b1111, 4'b0000,0,4'b0000,0,1,4'b0000,0)); // all dead
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0000,1,4'b0000,0,1,4'b0000,0)); // done at once
    vecs.push_back(mk(1,0,0,4'b0000, 4'b0000,1,4'b0000,0,1,4'b0000,0));
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b0000,0,1,4'b0000,0));
    vecs.push_back(mk(0,1,0,4'b0000, 4'b0000,0,4'b0000,0,1,4'b0000,0)); // draw armed
    vecs.push_back(mk(0,1,0,4'b0000, 4'b0000,0,4'b0000,0,1,4'b0000,1)); // straight to fin
    vecs.push_back(mk(0,0,0,4'b0000, 4'b0000,0,4'b0000,0,1,4'b0000,0));
    vecs.push_back(mk(0,0,1,4'b0001, 4'b0000,0,4'b1111,4,0,4'b0000,0)); // init beats hit

    // Reset state
    #12;
    chk("rst gen_move_en", gen_move_en, 0);
    chk("rst draw_en", draw_en, 0);
    chk("rst alive", alive, 4'b1111);
    chk("rst alive_count", alive_count, 4);
    chk("rst all_dead", all_dead, 0);
    chk("rst outs", {VGA_write, x_draw, y_draw, colour, gen_move_done, draw_done}, 0);
    reset = 1'b0;

    foreach (vecs[r]) begin
      gen_move = vecs[r].gm; draw = vecs[r].dr; init = vecs[r].in; hit = vecs[r].hit;
      @(posedge clock); #1;
      chk($sformatf("v%0d gen_move_en", r), gen_move_en, vecs[r].e_en);
      chk($sformatf("v%0d gen_move_done", r), gen_move_done, vecs[r].e_gdone);
      chk($sformatf("v%0d alive", r), alive, vecs[r].e_alive);
      chk($sformatf("v%0d alive_count", r), alive_count, vecs[r].e_cnt);
      chk($sformatf("v%0d all_dead", r), all_dead, vecs[r].e_dead);
      chk($sformatf("v%0d draw_en", r), draw_en, vecs[r].e_den);
      chk($sformatf("v%0d draw_done", r), draw_done, vecs[r].e_ddone);
      $display("vec %0d: gm=%b dr=%b init=%b hit=%b -> gen_en=%b gdone=%b alive=%b",
               r, vecs[r].gm, vecs[r].dr, vecs[r].in, vecs[r].hit,
               gen_move_en, gen_move_done, alive);
    end
    gen_move = 0; draw = 0; init = 0; hit = '0;
    @(posedge clock); #1;

    // gen_move_done must fall combinationally when the request drops
    begin
      bit seen;
      seen = 0;
      gen_move = 1'b1;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clock); #1;
        if (gen_move_done) seen = 1;
      end
      chk("gdone reached", seen, 1);
      gen_move = 1'b0;
      #1;
      chk("gdone comb drop", gen_move_done, 0);
      $display("gen_move_done drop: seen=%0d now=%b", seen, gen_move_done);
      @(posedge clock); #1;
    end

    // Full frame, then a kill of enemy 1 while it draws, then the next frame
    draw_frame("frame all", 4'b1111, 4'b0000);
    draw_frame("frame hit1", 4'b1111, 4'b0010);
    chk("hit1 alive", alive, 4'b1101);
    chk("hit1 alive_count", alive_count, 3);
    draw_frame("frame skip1", 4'b1101, 4'b0000);

    // Asynchronous reset in the middle of a sprite
    begin
      bit armed;
      armed = 0;
      draw = 1'b1;
      for (int c = 0; c < 20 && !armed; c++) begin
        @(posedge clock); #1;
        if (draw_en != '0) armed = 1;
      end
      chk("mid rst armed", armed, 1);
      chk("mid rst pre vga", VGA_write, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid rst draw_en", draw_en, 0);
      chk("mid rst VGA_write", VGA_write, 0);
      chk("mid rst x_draw", x_draw, 0);
      chk("mid rst alive", alive, 4'b1111);
      chk("mid rst alive_count", alive_count, 4);
      $display("mid reset: draw_en=%b VGA_write=%b alive=%b", draw_en, VGA_write, alive);
      draw = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("post rst draw_en", draw_en, 0);
      gen_move = 1'b1;
      @(posedge clock); #1;
      chk("post rst idle->gen", gen_move_en, 4'b0001);
      gen_move = 1'b0;
      @(posedge clock); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
